// File: rtl/axi_lite_rd_arbiter.sv
// Round-robin arbiter sharing one AXI-lite read-only slave among M read masters.
// One outstanding read at a time; the R reply is steered back to the granted requester only.
module axi_lite_rd_arbiter #(
  parameter int M          = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [M-1:0]            s_axi_ARVALID,
  output logic [M-1:0]            s_axi_ARREADY,
  input  logic [M*ADDR_WIDTH-1:0] s_axi_ARADDR,
  output logic [M-1:0]            s_axi_RVALID,
  input  logic [M-1:0]            s_axi_RREADY,
  output logic [DATA_WIDTH-1:0]   s_axi_RDATA,
  output logic [1:0]              s_axi_RRESP,
  output logic                    m_axi_ARVALID,
  input  logic                    m_axi_ARREADY,
  output logic [ADDR_WIDTH-1:0]   m_axi_ARADDR,
  input  logic                    m_axi_RVALID,
  output logic                    m_axi_RREADY,
  input  logic [DATA_WIDTH-1:0]   m_axi_RDATA,
  input  logic [1:0]              m_axi_RRESP
);

  localparam int GW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           grant_q;
  logic [GW-1:0]           last_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [GW:0]             pick;
  logic [GW-1:0]           win;
  logic                    ar_hs;
  logic                    r_done;

  // Scans last+1, last+2, ... mod M; the loop runs farthest-first so the nearest request
  // overwrites and therefore wins. MSB of the result flags that any request was found.
  function automatic logic [GW:0] rr_pick(input logic [M-1:0] req, input logic [GW-1:0] last);
    logic [GW:0]   res;
    logic [GW-1:0] idx;
    res = '0;
    for (int k = M; k >= 1; k--) begin
      idx = GW'((int'(last) + k) % M);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign pick = rr_pick(s_axi_ARVALID, last_q);
  assign win  = pick[GW-1:0];

  always_comb begin
    state_d       = state_q;
    s_axi_ARREADY = '0;
    s_axi_RVALID  = '0;
    m_axi_ARVALID = 1'b0;
    m_axi_RREADY  = 1'b0;
    ar_hs         = 1'b0;
    r_done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Held off while in reset so no requester believes an address was taken.
        if (pick[GW] && !ap_rst) begin
          s_axi_ARREADY[win] = 1'b1;
          ar_hs              = 1'b1;
          state_d            = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_axi_ARVALID = 1'b1;
        if (m_axi_ARREADY) state_d = ST_DATA;
      end
      ST_DATA: begin
        s_axi_RVALID[grant_q] = m_axi_RVALID;
        m_axi_RREADY          = s_axi_RREADY[grant_q];
        if (m_axi_RVALID && s_axi_RREADY[grant_q]) begin
          r_done  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered grant, latched address and round-robin pointer
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(M - 1);
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (ar_hs) begin
        grant_q <= win;
        addr_q  <= s_axi_ARADDR[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (r_done) last_q <= grant_q;
    end
  end

  assign m_axi_ARADDR = addr_q;
  assign s_axi_RDATA  = m_axi_RDATA;
  assign s_axi_RRESP  = m_axi_RRESP;

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Directed bench for axi_lite_rd_arbiter with three requesters and a small ROM slave model
// (addresses 9..15 answer SLVERR).
module tb_axi_lite_rd_arbiter;

  localparam int M  = 3;
  localparam int AW = 4;
  localparam int DW = 32;

  logic            ap_clk;
  logic            ap_rst;
  logic [M-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [M*AW-1:0] s_araddr;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0]   m_araddr;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;

  int total = 0;
  int bad   = 0;
  int ar_delay = 0;

  axi_lite_rd_arbiter #(.M(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .s_axi_ARVALID (s_arvalid),
    .s_axi_ARREADY (s_arready),
    .s_axi_ARADDR  (s_araddr),
    .s_axi_RVALID  (s_rvalid),
    .s_axi_RREADY  (s_rready),
    .s_axi_RDATA   (s_rdata),
    .s_axi_RRESP   (s_rresp),
    .m_axi_ARVALID (m_arvalid),
    .m_axi_ARREADY (m_arready),
    .m_axi_ARADDR  (m_araddr),
    .m_axi_RVALID  (m_rvalid),
    .m_axi_RREADY  (m_rready),
    .m_axi_RDATA   (m_rdata),
    .m_axi_RRESP   (m_rresp)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  function automatic logic [31:0] rom_data(input logic [AW-1:0] a);
    case (a)
      4'd0:    return 32'h24379827;
      4'd1:    return 32'ha639bf83;
      4'd2:    return 32'haec23ab1;
      4'd3:    return 32'h5ab32b97;
      4'd4:    return 32'hff1c4e78;
      4'd5:    return 32'h1234abcd;
      4'd6:    return 32'h0badf00d;
      4'd7:    return 32'h55aa33cc;
      4'd8:    return 32'h80000001;
      default: return 32'hdead0000 | 32'(a);
    endcase
  endfunction

  function automatic logic [1:0] rom_resp(input logic [AW-1:0] a);
    return (a >= 4'd9) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [M-1:0] oh(input int g);
    logic [M-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Slave: samples handshakes mid-cycle, updates its outputs just after the rising edge.
  logic          sl_ar_hs, sl_r_hs;
  logic [AW-1:0] sl_addr;
  int            ar_cnt;
  initial begin
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = 2'b00;
    ar_cnt    = 0;
    forever begin
      @(negedge ap_clk);
      #2;
      sl_ar_hs = m_arvalid && m_arready;
      sl_r_hs  = m_rvalid && m_rready;
      sl_addr  = m_araddr;
      @(posedge ap_clk);
      #1;
      if (ap_rst) begin
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        ar_cnt    = 0;
      end else begin
        if (sl_r_hs) m_rvalid = 1'b0;
        if (sl_ar_hs) begin
          m_arready = 1'b0;
          m_rvalid  = 1'b1;
          m_rdata   = rom_data(sl_addr);
          m_rresp   = rom_resp(sl_addr);
          ar_cnt    = 0;
        end else if (m_arvalid && !m_arready) begin
          if (ar_cnt >= ar_delay) m_arready = 1'b1;
          else ar_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int r, input logic [AW-1:0] a);
    s_araddr[r*AW +: AW] = a;
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst    = 1'b1;
    s_arvalid = '0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
  endtask

  initial begin
    int            g, exp_g, stall, gmin, gmax;
    bit            ok;
    logic [AW-1:0] a;
    logic [AW-1:0] req_addr [M];
    int            gcnt [M];

    s_arvalid = '0;
    s_araddr  = '0;
    s_rready  = '0;
    ap_rst    = 1'b1;

    // Reset state, with requests pending to show ARREADY is held off
    @(negedge ap_clk);
    s_arvalid = 3'b011;
    #1;
    chk("rst_arready", 32'(s_arready), 32'h0);
    chk("rst_rvalid", 32'(s_rvalid), 32'h0);
    chk("rst_m_arvalid", 32'(m_arvalid), 32'h0);
    chk("rst_m_rready", 32'(m_rready), 32'h0);
    chk("rst_m_araddr", 32'(m_araddr), 32'h0);
    @(negedge ap_clk);
    s_arvalid = '0;
    ap_rst    = 1'b0;

    // 1: single zero-wait read, req0 addr 3
    @(negedge ap_clk);
    s_rready = 3'b111;
    set_addr(0, 4'd3);
    s_arvalid = 3'b001;
    #1 chk("t1_arready", 32'(s_arready), 32'h1);
    @(negedge ap_clk);
    s_arvalid = '0;
    #1;
    chk("t1_m_arvalid", 32'(m_arvalid), 32'h1);
    chk("t1_m_araddr", 32'(m_araddr), 32'h3);
    chk("t1_arready_addr", 32'(s_arready), 32'h0);
    @(negedge ap_clk);
    #1;
    chk("t1_rvalid", 32'(s_rvalid), 32'h1);
    chk("t1_rdata", s_rdata, 32'h5ab32b97);
    chk("t1_rresp", 32'(s_rresp), 32'h0);
    chk("t1_m_rready", 32'(m_rready), 32'h1);
    @(negedge ap_clk);
    #1 chk("t1_idle_rvalid", 32'(s_rvalid), 32'h0);

    // 2: req0 and req1 together after reset -> req0 first, then req1
    do_reset();
    @(negedge ap_clk);
    set_addr(0, 4'd1);
    set_addr(1, 4'd2);
    s_arvalid = 3'b011;
    s_rready  = 3'b111;
    #1 chk("t2_grant0", 32'(s_arready), 32'h1);
    @(negedge ap_clk);
    s_arvalid = 3'b010;
    #1;
    chk("t2_arready_addr", 32'(s_arready), 32'h0);
    chk("t2_m_araddr0", 32'(m_araddr), 32'h1);
    @(negedge ap_clk);
    #1;
    chk("t2_rvalid0", 32'(s_rvalid), 32'h1);
    chk("t2_rdata0", s_rdata, 32'ha639bf83);
    @(negedge ap_clk);
    #1;
    chk("t2_grant1", 32'(s_arready), 32'h2);
    chk("t2_rvalid_idle", 32'(s_rvalid), 32'h0);
    @(negedge ap_clk);
    s_arvalid = '0;
    #1 chk("t2_m_araddr1", 32'(m_araddr), 32'h2);
    @(negedge ap_clk);
    #1;
    chk("t2_rvalid1", 32'(s_rvalid), 32'h2);
    chk("t2_rdata1", s_rdata, 32'haec23ab1);
    @(negedge ap_clk);

    // 3: req0 stalls RREADY for 5 cycles while req1 waits
    set_addr(0, 4'd4);
    set_addr(1, 4'd5);
    s_arvalid = 3'b011;
    s_rready  = 3'b000;
    #1 chk("t3_grant0", 32'(s_arready), 32'h1);
    @(negedge ap_clk);
    s_arvalid = 3'b010;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      #1;
      chk("t3_rvalid", 32'(s_rvalid), 32'h1);
      chk("t3_m_rready", 32'(m_rready), 32'h0);
      chk("t3_rdata_hold", s_rdata, 32'hff1c4e78);
      chk("t3_req1_blocked", 32'(s_arready), 32'h0);
    end
    @(negedge ap_clk);
    s_rready = 3'b001;
    #1 chk("t3_m_rready_up", 32'(m_rready), 32'h1);
    @(negedge ap_clk);
    s_rready = 3'b111;
    #1 chk("t3_grant1", 32'(s_arready), 32'h2);
    @(negedge ap_clk);
    s_arvalid = '0;
    @(negedge ap_clk);
    #1;
    chk("t3_rvalid1", 32'(s_rvalid), 32'h2);
    chk("t3_rdata1", s_rdata, 32'h1234abcd);
    @(negedge ap_clk);

    // 4: slave ARREADY delayed 0..4 cycles; address must hold; 9 and 10 return SLVERR
    for (int d = 0; d <= 4; d++) begin
      ar_delay = d;
      set_addr(2, AW'(d + 6));
      s_arvalid = 3'b100;
      #1 chk("t4_grant2", 32'(s_arready), 32'h4);
      @(negedge ap_clk);
      s_arvalid = '0;
      for (int c = 0; c <= d; c++) begin
        #1;
        chk("t4_m_arvalid", 32'(m_arvalid), 32'h1);
        chk("t4_m_araddr", 32'(m_araddr), 32'(d + 6));
        @(negedge ap_clk);
      end
      #1;
      chk("t4_m_arvalid_done", 32'(m_arvalid), 32'h0);
      chk("t4_rvalid", 32'(s_rvalid), 32'h4);
      chk("t4_rdata", s_rdata, rom_data(AW'(d + 6)));
      chk("t4_rresp", 32'(s_rresp), 32'(rom_resp(AW'(d + 6))));
      @(negedge ap_clk);
    end
    ar_delay = 0;

    // 5: reset pulsed in DATA; afterwards req0 wins again
    set_addr(0, 4'd0);
    set_addr(1, 4'd8);
    s_arvalid = 3'b011;
    s_rready  = 3'b000;
    #1 chk("t5_grant0", 32'(s_arready), 32'h1);
    @(negedge ap_clk);
    @(negedge ap_clk);
    #1 chk("t5_rvalid_pre", 32'(s_rvalid), 32'h1);
    #2 ap_rst = 1'b1;
    #1;
    chk("t5_rst_rvalid", 32'(s_rvalid), 32'h0);
    chk("t5_rst_m_rready", 32'(m_rready), 32'h0);
    chk("t5_rst_m_arvalid", 32'(m_arvalid), 32'h0);
    chk("t5_rst_arready", 32'(s_arready), 32'h0);
    @(negedge ap_clk);
    ap_rst   = 1'b0;
    s_rready = 3'b111;
    #1 chk("t5_regrant0", 32'(s_arready), 32'h1);
    @(negedge ap_clk);
    s_arvalid = 3'b010;
    @(negedge ap_clk);
    #1;
    chk("t5_rvalid0", 32'(s_rvalid), 32'h1);
    chk("t5_rdata0", s_rdata, 32'h24379827);
    @(negedge ap_clk);
    #1 chk("t5_grant1", 32'(s_arready), 32'h2);
    @(negedge ap_clk);
    s_arvalid = '0;
    @(negedge ap_clk);
    #1 chk("t5_rdata1", s_rdata, 32'h80000001);
    @(negedge ap_clk);

    // 6: all requesters continuously valid; grants rotate 2,0,1,... with random stalls
    s_rready = '0;
    for (int r = 0; r < M; r++) begin
      req_addr[r] = AW'($urandom_range(0, 15));
      set_addr(r, req_addr[r]);
      gcnt[r] = 0;
    end
    s_arvalid = 3'b111;
    exp_g = 2;
    for (int n = 0; n < 30; n++) begin
      ar_delay = $urandom_range(0, 2);
      #1;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (s_arready != '0) begin
          ok = 1'b1;
          break;
        end
        @(negedge ap_clk);
        #1;
      end
      chk("t6_ar_timeout", 32'(ok), 32'h1);
      chk("t6_grant", 32'(s_arready), 32'(oh(exp_g)));
      g = exp_g;
      a = req_addr[g];
      gcnt[g]++;
      @(negedge ap_clk);
      req_addr[g] = AW'($urandom_range(0, 15));
      set_addr(g, req_addr[g]);
      #1;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (s_rvalid[g]) begin
          ok = 1'b1;
          break;
        end
        chk("t6_m_arvalid", 32'(m_arvalid), 32'h1);
        chk("t6_m_araddr", 32'(m_araddr), 32'(a));
        @(negedge ap_clk);
        #1;
      end
      chk("t6_r_timeout", 32'(ok), 32'h1);
      chk("t6_rvalid", 32'(s_rvalid), 32'(oh(g)));
      chk("t6_rdata", s_rdata, rom_data(a));
      chk("t6_rresp", 32'(s_rresp), 32'(rom_resp(a)));
      stall = $urandom_range(0, 2);
      repeat (stall) begin
        @(negedge ap_clk);
        #1;
        chk("t6_stall_m_rready", 32'(m_rready), 32'h0);
        chk("t6_stall_rdata", s_rdata, rom_data(a));
      end
      @(negedge ap_clk);
      s_rready[g] = 1'b1;
      #1 chk("t6_m_rready", 32'(m_rready), 32'h1);
      @(negedge ap_clk);
      s_rready = '0;
      if (n == 29) s_arvalid = '0;
      exp_g = (exp_g + 1) % M;
    end
    gmin = gcnt[0];
    gmax = gcnt[0];
    for (int r = 1; r < M; r++) begin
      if (gcnt[r] < gmin) gmin = gcnt[r];
      if (gcnt[r] > gmax) gmax = gcnt[r];
    end
    chk("t6_fairness", 32'(gmax - gmin <= 1), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
